// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Target end of the mem_intf bus. Holds a DEPTH x DATA_W storage array and
// services single-beat writes and reads. After every reset a clear sweep
// loads CLR_VAL into each location, one per cycle. Reads complete RD_LAT
// edges after being sampled (counting the sampling edge), flagged by a
// one-cycle rvalid pulse. Any request that cannot be honoured (during the
// sweep, while a read is pending, or read+write together) sets a sticky err.
//
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous, active-high reset
//   read      in   1       read request
//   write     in   1       write request
//   addr      in   ADDR_W  request address
//   data_in   in   DATA_W  write data
//   data_out  out  DATA_W  read data, held until the next read completes
//   rvalid    out  1       one-cycle pulse when data_out is new
//   busy      out  1       high while requests are not accepted
//   err       out  1       sticky protocol-error flag, cleared by rst only
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int                ADDR_W  = 5,
    parameter int                DATA_W  = 8,
    parameter int                DEPTH   = 2**ADDR_W,
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    // Wide enough for RD_LAT-1 with RD_LAT up to 4.
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        RD_WAIT
    } state_t;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] clr_ptr_q,  clr_ptr_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              rvalid_q,   rvalid_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        rvalid_d   = 1'b0;
        busy_d     = busy_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = CLR_VAL;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (read || write)
                    err_d = 1'b1;
                // Last location written at this edge: open for business.
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end

            IDLE: begin
                if (read && write) begin
                    err_d = 1'b1;
                end else if (write) begin
                    mem_we = 1'b1;
                end else if (read) begin
                    addr_d = addr;
                    if (RD_LAT == 1) begin
                        data_out_d = mem_q[addr];
                        rvalid_d   = 1'b1;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                        busy_d  = 1'b1;
                    end
                end
            end

            RD_WAIT: begin
                if (read || write)
                    err_d = 1'b1;
                cnt_d = cnt_q - 1'b1;
                // Completes on the edge that sees the count at 1, giving a
                // total of RD_LAT edges from the sampling edge.
                if (cnt_q == CNT_W'(1)) begin
                    data_out_d = mem_q[addr_q];
                    rvalid_d   = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = CLEAR;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage needs no reset: the clear sweep initialises it after every rst.
    always_ff @(posedge clk) begin
        if (!rst && mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    assign data_out = data_out_q;
    assign rvalid   = rvalid_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // u_dut1: RD_LAT=1, u_dut3: RD_LAT=3; shared clock and reset.
    logic       rd1 = 0, wr1 = 0;
    logic [4:0] ad1 = 0;
    logic [7:0] di1 = 0, do1;
    logic       rv1, bs1, er1;

    logic       rd3 = 0, wr3 = 0;
    logic [4:0] ad3 = 0;
    logic [7:0] di3 = 0, do3;
    logic       rv3, bs3, er3;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arrays of last-written values.
    logic [7:0] m1 [32];
    logic [7:0] m3 [32];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .read(rd1), .write(wr1), .addr(ad1),
        .data_in(di1), .data_out(do1), .rvalid(rv1), .busy(bs1), .err(er1)
    );

    mem_responder #(.ADDR_W(5), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .read(rd3), .write(wr3), .addr(ad3),
        .data_in(di3), .data_out(do3), .rvalid(rv3), .busy(bs3), .err(er3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr1_op(input logic [4:0] a, input logic [7:0] d);
        wr1 = 1; ad1 = a; di1 = d;
        step();
        wr1 = 0;
        m1[a] = d;
    endtask

    task automatic rd1_op(input string tag, input logic [4:0] a);
        rd1 = 1; ad1 = a;
        step();
        rd1 = 0;
        chk({tag, "_rv"}, 32'(rv1), 32'd1);
        chk({tag, "_data"}, 32'(do1), 32'(m1[a]));
    endtask

    // Read on the RD_LAT=3 instance: rvalid expected 2 edges after sampling.
    task automatic rd3_op(input string tag, input logic [4:0] a);
        int n;
        rd3 = 1; ad3 = a;
        step();
        rd3 = 0;
        chk({tag, "_busy"}, 32'(bs3), 32'd1);
        n = 0;
        while (!rv3 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd2);
        chk({tag, "_data"}, 32'(do3), 32'(m3[a]));
        chk({tag, "_busy_done"}, 32'(bs3), 32'd0);
        step();
        chk({tag, "_rv_pulse"}, 32'(rv3), 32'd0);
    endtask

    // Busy cycles counted from the reset edge (which already shows busy=1).
    task automatic count_clear(output int n);
        n = 1;
        while (bs3 && n < 100) begin
            step();
            if (bs3) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        int n;
        logic [4:0] a;
        logic [7:0] d;
        logic [4:0] perm [32];

        // ---- 1: reset and clear sweep ----
        rst = 1;
        step();
        chk("rst_busy", 32'(bs1), 32'd1);
        chk("rst_rvalid", 32'(rv1), 32'd0);
        chk("rst_dout", 32'(do1), 32'd0);
        chk("rst_err", 32'(er1), 32'd0);
        rst = 0;
        for (int i = 0; i < 32; i++) begin m1[i] = 8'h00; m3[i] = 8'h00; end
        count_clear(n);
        chk("clr_cycles", 32'(n), 32'd32);
        chk("clr_busy1", 32'(bs1), 32'd0);
        for (int i = 0; i < 32; i++) rd1_op("clr_rd", 5'(i));
        step();
        chk("clr_rv_idle", 32'(rv1), 32'd0);

        // ---- 2: data=addr, back-to-back readback ----
        for (int i = 0; i < 32; i++) wr1_op(5'(i), 8'(i));
        rd1 = 1;
        for (int i = 0; i < 32; i++) begin
            ad1 = 5'(i);
            step();
            chk("b2b_rv", 32'(rv1), 32'd1);
            chk("b2b_data", 32'(do1), 32'(i));
        end
        rd1 = 0;
        step();
        chk("b2b_rv_end", 32'(rv1), 32'd0);
        chk("b2b_dout_hold", 32'(do1), 32'd31);
        chk("b2b_err", 32'(er1), 32'd0);

        // ---- 3: random writes against the model, then shuffled readback ----
        for (int i = 0; i < 64; i++) begin
            a = 5'($urandom_range(0, 31));
            d = 8'($urandom_range(8'h20, 8'h7E));
            wr1_op(a, d);
        end
        for (int i = 0; i < 32; i++) perm[i] = 5'(i);
        for (int i = 31; i > 0; i--) begin
            int j;
            j = $urandom_range(0, i);
            a = perm[i]; perm[i] = perm[j]; perm[j] = a;
        end
        for (int i = 0; i < 32; i++) rd1_op("rnd_rd", perm[i]);
        chk("rnd_err", 32'(er1), 32'd0);

        // ---- 4: RD_LAT=3 ----
        wr3 = 1; ad3 = 5'd5; di3 = 8'h41;
        step();
        wr3 = 0; m3[5] = 8'h41;
        rd3_op("lat3", 5'd5);
        chk("lat3_err0", 32'(er3), 32'd0);
        // read while busy: ignored, sets err
        rd3 = 1; ad3 = 5'd5;
        step();
        ad3 = 5'd9;
        step();
        rd3 = 0;
        chk("lat3_busy_err", 32'(er3), 32'd1);
        chk("lat3_busy_rv", 32'(rv3), 32'd0);
        step();
        chk("lat3_rv", 32'(rv3), 32'd1);
        chk("lat3_data", 32'(do3), 32'h41);
        step();
        chk("lat3_no_extra_rv", 32'(rv3), 32'd0);

        // ---- 5: read+write together ----
        d = m1[3];
        rd1 = 1; wr1 = 1; ad1 = 5'd3; di1 = 8'hFF;
        step();
        rd1 = 0; wr1 = 0;
        chk("rw_rv", 32'(rv1), 32'd0);
        chk("rw_err", 32'(er1), 32'd1);
        rd1_op("rw_mem", 5'd3);
        chk("rw_mem_kept", 32'(do1), 32'(d));
        for (int i = 0; i < 5; i++) step();
        chk("rw_err_sticky", 32'(er1), 32'd1);

        // ---- 6: reset in the middle of an RD_LAT=3 read ----
        rd3 = 1; ad3 = 5'd5;
        step();
        rd3 = 0;
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_rv", 32'(rv3), 32'd0);
        chk("mid_rst_dout", 32'(do3), 32'd0);
        chk("mid_rst_busy", 32'(bs3), 32'd1);
        chk("mid_rst_err3", 32'(er3), 32'd0);
        chk("mid_rst_err1", 32'(er1), 32'd0);
        for (int i = 0; i < 32; i++) begin m1[i] = 8'h00; m3[i] = 8'h00; end
        // a request during the sweep is flagged
        wr1 = 1; ad1 = 5'd9; di1 = 8'h55;
        n = 1;
        step();
        if (bs3) n++;
        wr1 = 0;
        while (bs3 && n < 100) begin
            step();
            if (bs3) n++;
        end
        chk("mid_rst_clr_cycles", 32'(n), 32'd32);
        chk("clr_req_err", 32'(er1), 32'd1);
        step();
        chk("mid_rst_no_rv", 32'(rv3), 32'd0);
        rd3_op("mid_rst_rd5", 5'd5);
        rd1_op("clr2_rd9", 5'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
